// File: rtl/magnitude_sqrt_core_if.sv
// Operand and result handshake bundle for magnitude_sqrt_core.
// The master side supplies operand pairs and consumes results; the core is the slave.
interface magnitude_sqrt_core_if #(
   parameter int DATA_WIDTH = 16
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_x;
   logic signed [DATA_WIDTH-1:0] in_y;
   logic                         out_valid;
   logic                         out_ready;
   logic        [DATA_WIDTH-1:0] out_mag;
   logic                         out_exact;

   modport master (
      output in_valid, in_x, in_y, out_ready,
      input  in_ready, out_valid, out_mag, out_exact
   );

   modport slave (
      input  in_valid, in_x, in_y, out_ready,
      output in_ready, out_valid, out_mag, out_exact
   );
endinterface

// File: rtl/magnitude_sqrt_core.sv
// Iterative floor(sqrt(x^2 + y^2)) core: one squaring cycle, then a restoring
// two-bits-per-cycle square root over DATA_WIDTH cycles, with registered handshakes.
module magnitude_sqrt_core #(
   parameter int DATA_WIDTH  = 16,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   csi_clock_clk,
   input  logic                   csi_clock_reset,
   input  logic                   clear,
   magnitude_sqrt_core_if.slave   bus,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] result_count
);

   localparam int DW    = DATA_WIDTH;
   localparam int RW    = 2 * DATA_WIDTH;
   localparam int REM_W = DATA_WIDTH + 2;
   localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SQUARE,
      S_ROOT,
      S_OUT
   } state_t;

   state_t                  state_q, state_d;
   logic signed [DW-1:0]    x_q, x_d;
   logic signed [DW-1:0]    y_q, y_d;
   logic        [RW-1:0]    rad_q, rad_d;
   logic        [REM_W-1:0] rem_q, rem_d;
   logic        [DW-1:0]    root_q, root_d;
   logic        [CNT_W-1:0] cnt_q, cnt_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic        [DW-1:0]    out_mag_q, out_mag_d;
   logic                    out_exact_q, out_exact_d;
   logic                    busy_q, busy_d;
   logic [COUNT_WIDTH-1:0]  count_q, count_d;

   logic        [REM_W-1:0] step_rem;
   logic        [DW-1:0]    step_root;

   // Square of a signed value; the true result always fits in RW unsigned bits,
   // including the -2^(DW-1) extreme.
   function automatic logic [RW-1:0] square_u(input logic signed [DW-1:0] v);
      logic signed [RW-1:0] ve;
      logic signed [RW-1:0] p;
      ve = {{DW{v[DW-1]}}, v};
      p  = ve * ve;
      return $unsigned(p);
   endfunction

   // One restoring root digit: bring down the next two radicand bits and try (root<<2)|1.
   function automatic void root_step(
      input  logic [REM_W-1:0] rem,
      input  logic [1:0]       top,
      input  logic [DW-1:0]    root,
      output logic [REM_W-1:0] rem_n,
      output logic [DW-1:0]    root_n
   );
      logic [REM_W-1:0] shifted;
      logic [REM_W-1:0] trial;
      shifted = {rem[DW-1:0], top};
      trial   = {root, 2'b01};
      if (shifted >= trial) begin
         rem_n  = shifted - trial;
         root_n = {root[DW-2:0], 1'b1};
      end else begin
         rem_n  = shifted;
         root_n = {root[DW-2:0], 1'b0};
      end
   endfunction

   always_comb begin
      step_rem  = '0;
      step_root = '0;
      root_step(rem_q, rad_q[RW-1 -: 2], root_q, step_rem, step_root);
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      rad_d       = rad_q;
      rem_d       = rem_q;
      root_d      = root_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_mag_d   = out_mag_q;
      out_exact_d = out_exact_q;
      count_d     = count_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               x_d     = bus.in_x;
               y_d     = bus.in_y;
               state_d = S_SQUARE;
            end
         end
         S_SQUARE: begin
            rad_d   = square_u(x_q) + square_u(y_q);
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = CNT_W'(DW - 1);
            state_d = S_ROOT;
         end
         S_ROOT: begin
            rem_d  = step_rem;
            root_d = step_root;
            rad_d  = {rad_q[RW-3:0], 2'b00};
            if (cnt_q == '0) begin
               out_mag_d   = step_root;
               out_exact_d = (step_rem == '0);
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               count_d     = count_q + 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over every handshake, including a result completing this cycle.
      if (clear) begin
         state_d     = S_IDLE;
         x_d         = x_q;
         y_d         = y_q;
         out_valid_d = 1'b0;
         out_mag_d   = out_mag_q;
         out_exact_d = out_exact_q;
         count_d     = count_q;
      end

      in_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
      if (csi_clock_reset) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         rad_q       <= '0;
         rem_q       <= '0;
         root_q      <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_mag_q   <= '0;
         out_exact_q <= 1'b0;
         busy_q      <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         rad_q       <= rad_d;
         rem_q       <= rem_d;
         root_q      <= root_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_mag_q   <= out_mag_d;
         out_exact_q <= out_exact_d;
         busy_q      <= busy_d;
         count_q     <= count_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_mag   = out_mag_q;
   assign bus.out_exact = out_exact_q;
   assign busy          = busy_q;
   assign result_count  = count_q;

endmodule
